apb_master_n: RTL and testbench

Parametrised APB master that turns single-transaction requests from the processor bus into APB SETUP/ACCESS cycles on one of `NUM_SLAVES` slaves. It is the next generation of the two-slave APB master. It adds:
- one-hot per-slave select
- per-slave `pready` and `pslverr` with read-data muxing
- an ACCESS-phase timeout
- back-to-back transfers

It sits between the processor bus and the `apb_slave` memory bridges.

---
 rtl/apb_pkg.sv | 13 +
 rtl/apb_wait_timer.sv | 37 +++
 rtl/apb_master_n.sv | 163 ++++++++++++++++
 tb/tb_apb_master_n.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB types and default widths for the master and slave bridges.
package apb_pkg;

   localparam int APB_DATA_W = 8;
   localparam int APB_ADDR_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_t;

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait counter; expired flags the last allowed wait cycle.
module apb_wait_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   generate
      if (TIMEOUT == 0) begin : g_off
         logic w_unused;
         assign w_unused = &{1'b0, clk, reset, clr, en};
         assign expired  = 1'b0;
      end else begin : g_on
         localparam int CW = $clog2(TIMEOUT + 1);
         localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);

         logic [CW-1:0] r_cnt;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               r_cnt <= '0;
            end else if (clr) begin
               r_cnt <= '0;
            end else if (en && !expired) begin
               r_cnt <= r_cnt + CW'(1);
            end
         end

         assign expired = (r_cnt == LIM);
      end
   endgenerate

endmodule

// File: rtl/apb_master_n.sv
// N-slave APB master: one request at a time, SETUP/ACCESS with timeout
// and back-to-back issue from the completion cycle.
module apb_master_n
   import apb_pkg::*;
#(
   parameter int DATA_W     = APB_DATA_W,
   parameter int ADDR_W     = APB_ADDR_W,
   parameter int NUM_SLAVES = 4,
   parameter int SEL_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
   parameter int TIMEOUT    = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         write,
   input  logic [SEL_W-1:0]             sel,
   input  logic [ADDR_W-1:0]            addr,
   input  logic [DATA_W-1:0]            wdata,
   output logic [DATA_W-1:0]            rdata,
   output logic                         stable,
   output logic                         error,
   output logic                         busy,
   output logic [ADDR_W-1:0]            paddr,
   output logic                         pwrite,
   output logic [DATA_W-1:0]            pwdata,
   output logic [NUM_SLAVES-1:0]        psel,
   output logic                         penable,
   input  logic [NUM_SLAVES*DATA_W-1:0] prdata,
   input  logic [NUM_SLAVES-1:0]        pready,
   input  logic [NUM_SLAVES-1:0]        pslverr
);

   apb_state_t              r_state;
   logic [ADDR_W-1:0]       r_paddr;
   logic                    r_pwrite;
   logic [DATA_W-1:0]       r_pwdata;
   logic [NUM_SLAVES-1:0]   r_psel;
   logic                    r_penable;
   logic [DATA_W-1:0]       r_rdata;
   logic                    r_stable;
   logic                    r_error;
   logic                    r_busy;

   logic                    w_sel_ok;
   logic [NUM_SLAVES-1:0]   w_sel_oh;
   logic                    w_rdy;
   logic                    w_slverr;
   logic [DATA_W-1:0]       w_prd;
   logic                    w_expired;

   assign w_sel_ok = (32'(sel) < NUM_SLAVES);

   always_comb begin
      w_sel_oh = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         w_sel_oh[i] = (32'(sel) == 32'(i));
      end
   end

   // The registered one-hot select doubles as the lane index.
   assign w_rdy    = |(pready & r_psel);
   assign w_slverr = |(pslverr & r_psel);

   always_comb begin
      w_prd = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (r_psel[i]) begin
            w_prd = w_prd | prdata[i*DATA_W +: DATA_W];
         end
      end
   end

   apb_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clr     (r_state == ST_SETUP),
      .en      ((r_state == ST_ACCESS) && !w_rdy),
      .expired (w_expired)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_paddr   <= '0;
         r_pwrite  <= 1'b0;
         r_pwdata  <= '0;
         r_psel    <= '0;
         r_penable <= 1'b0;
         r_rdata   <= '0;
         r_stable  <= 1'b0;
         r_error   <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_stable <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (start && w_sel_ok) begin
                  r_paddr  <= addr;
                  r_pwrite <= write;
                  r_pwdata <= wdata;
                  r_psel   <= w_sel_oh;
                  r_busy   <= 1'b1;
                  r_state  <= ST_SETUP;
               end else if (start) begin
                  r_stable <= 1'b1;
                  r_error  <= 1'b1;
               end
            end
            ST_SETUP: begin
               r_penable <= 1'b1;
               r_state   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (w_rdy) begin
                  r_stable  <= 1'b1;
                  r_error   <= w_slverr;
                  r_penable <= 1'b0;
                  if (!r_pwrite) begin
                     r_rdata <= w_prd;
                  end
                  if (start && w_sel_ok) begin
                     r_paddr  <= addr;
                     r_pwrite <= write;
                     r_pwdata <= wdata;
                     r_psel   <= w_sel_oh;
                     r_state  <= ST_SETUP;
                  end else begin
                     r_psel  <= '0;
                     r_busy  <= 1'b0;
                     r_state <= ST_IDLE;
                  end
               end else if (w_expired) begin
                  r_psel    <= '0;
                  r_penable <= 1'b0;
                  r_busy    <= 1'b0;
                  r_stable  <= 1'b1;
                  r_error   <= 1'b1;
                  r_state   <= ST_IDLE;
               end
            end
            default: begin
               r_psel    <= '0;
               r_penable <= 1'b0;
               r_busy    <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

   assign paddr   = r_paddr;
   assign pwrite  = r_pwrite;
   assign pwdata  = r_pwdata;
   assign psel    = r_psel;
   assign penable = r_penable;
   assign rdata   = r_rdata;
   assign stable  = r_stable;
   assign error   = r_error;
   assign busy    = r_busy;

endmodule

// File: tb/tb_apb_master_n.sv
// Directed bench for apb_master_n: 4 slaves, 3-bit sel, TIMEOUT=4.
module tb_apb_master_n;

   logic        clk;
   logic        reset;
   logic        start;
   logic        write;
   logic [2:0]  sel;
   logic [7:0]  addr;
   logic [7:0]  wdata;
   logic [7:0]  rdata;
   logic        stable;
   logic        error;
   logic        busy;
   logic [7:0]  paddr;
   logic        pwrite;
   logic [7:0]  pwdata;
   logic [3:0]  psel;
   logic        penable;
   logic [31:0] prdata;
   logic [3:0]  pready;
   logic [3:0]  pslverr;

   int n_chk = 0;
   int n_err = 0;

   apb_master_n #(
      .DATA_W     (8),
      .ADDR_W     (8),
      .NUM_SLAVES (4),
      .SEL_W      (3),
      .TIMEOUT    (4)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .write   (write),
      .sel     (sel),
      .addr    (addr),
      .wdata   (wdata),
      .rdata   (rdata),
      .stable  (stable),
      .error   (error),
      .busy    (busy),
      .paddr   (paddr),
      .pwrite  (pwrite),
      .pwdata  (pwdata),
      .psel    (psel),
      .penable (penable),
      .prdata  (prdata),
      .pready  (pready),
      .pslverr (pslverr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Present a request at a negedge; it is sampled at the next posedge.
   task automatic req(input logic w, input logic [2:0] s,
                      input logic [7:0] a, input logic [7:0] d);
      start = 1'b1;
      write = w;
      sel   = s;
      addr  = a;
      wdata = d;
   endtask

   initial begin
      reset   = 1'b0;
      start   = 1'b0;
      write   = 1'b0;
      sel     = '0;
      addr    = '0;
      wdata   = '0;
      prdata  = '0;
      pready  = '0;
      pslverr = '0;

      tick();
      tick();
      check("rst_psel",    32'(psel),    0);
      check("rst_penable", 32'(penable), 0);
      check("rst_paddr",   32'(paddr),   0);
      check("rst_pwdata",  32'(pwdata),  0);
      check("rst_rdata",   32'(rdata),   0);
      check("rst_stable",  32'(stable),  0);
      check("rst_error",   32'(error),   0);
      check("rst_busy",    32'(busy),    0);
      reset = 1'b1;
      tick();

      // Zero-wait write to slave 2
      req(1'b1, 3'd2, 8'h10, 8'hA5);
      tick();
      start = 1'b0;
      check("w_c1_psel",    32'(psel),    32'h4);
      check("w_c1_penable", 32'(penable), 0);
      check("w_c1_busy",    32'(busy),    1);
      tick();
      pready = 4'b0100;
      check("w_c2_psel",    32'(psel),    32'h4);
      check("w_c2_penable", 32'(penable), 1);
      check("w_c2_paddr",   32'(paddr),   32'h10);
      check("w_c2_pwdata",  32'(pwdata),  32'hA5);
      check("w_c2_pwrite",  32'(pwrite),  1);
      check("w_c2_stable",  32'(stable),  0);
      tick();
      pready = 4'b0000;
      check("w_c3_stable", 32'(stable), 1);
      check("w_c3_error",  32'(error),  0);
      check("w_c3_psel",   32'(psel),   0);
      check("w_c3_busy",   32'(busy),   0);
      check("w_c3_rdata",  32'(rdata),  0);
      tick();
      check("w_c4_stable", 32'(stable), 0);

      // Read from slave 1 with 3 wait cycles; slave 2 ready is noise
      prdata = {8'h00, 8'hFF, 8'h3C, 8'h00};
      req(1'b0, 3'd1, 8'h44, 8'h00);
      tick();
      start = 1'b0;
      check("r_c1_psel",  32'(psel),  32'h2);
      check("r_c1_paddr", 32'(paddr), 32'h44);
      for (int c = 2; c <= 4; c++) begin
         tick();
         pready = 4'b0100;
         check("r_wait_penable", 32'(penable), 1);
         check("r_wait_paddr",   32'(paddr),   32'h44);
         check("r_wait_stable",  32'(stable),  0);
      end
      tick();
      pready = 4'b0110;
      check("r_c5_penable", 32'(penable), 1);
      check("r_c5_paddr",   32'(paddr),   32'h44);
      tick();
      pready = 4'b0000;
      check("r_c6_stable", 32'(stable), 1);
      check("r_c6_rdata",  32'(rdata),  32'h3C);
      check("r_c6_error",  32'(error),  0);
      tick();

      // Slave error on slave 0
      req(1'b1, 3'd0, 8'h05, 8'h99);
      tick();
      start = 1'b0;
      tick();
      pready  = 4'b0001;
      pslverr = 4'b0001;
      tick();
      pready = 4'b0000;
      check("e_stable", 32'(stable), 1);
      check("e_error",  32'(error),  1);
      tick();
      check("e_hold",   32'(error),  1);

      // Clean read from slave 3; unselected pslverr is ignored
      prdata = {8'h5A, 8'h77, 8'h3C, 8'h11};
      req(1'b0, 3'd3, 8'h33, 8'h00);
      tick();
      start = 1'b0;
      check("c_c1_psel", 32'(psel), 32'h8);
      tick();
      pready = 4'b1000;
      tick();
      pready  = 4'b0000;
      pslverr = 4'b0000;
      check("c_stable", 32'(stable), 1);
      check("c_error",  32'(error),  0);
      check("c_rdata",  32'(rdata),  32'h5A);
      tick();

      // Timeout on slave 2; slave 0 ready is noise
      req(1'b0, 3'd2, 8'h66, 8'h00);
      tick();
      start = 1'b0;
      check("t_c1_psel", 32'(psel), 32'h4);
      for (int c = 2; c <= 5; c++) begin
         tick();
         pready = 4'b0001;
         check("t_acc_psel",    32'(psel),    32'h4);
         check("t_acc_penable", 32'(penable), 1);
         check("t_acc_stable",  32'(stable),  0);
      end
      tick();
      pready = 4'b0000;
      check("t_c6_psel",    32'(psel),    0);
      check("t_c6_penable", 32'(penable), 0);
      check("t_c6_stable",  32'(stable),  1);
      check("t_c6_error",   32'(error),   1);
      check("t_c6_rdata",   32'(rdata),   32'h5A);
      check("t_c6_busy",    32'(busy),    0);
      tick();
      check("t_c7_stable", 32'(stable), 0);

      // Back-to-back: slave 1 then slave 3
      req(1'b1, 3'd1, 8'h20, 8'h11);
      tick();
      check("b_c1_psel", 32'(psel), 32'h2);
      req(1'b1, 3'd3, 8'h30, 8'h22);
      tick();
      pready = 4'b0010;
      check("b_c2_penable", 32'(penable), 1);
      check("b_c2_paddr",   32'(paddr),   32'h20);
      check("b_c2_pwdata",  32'(pwdata),  32'h11);
      tick();
      start  = 1'b0;
      pready = 4'b1000;
      check("b_c3_stable",  32'(stable),  1);
      check("b_c3_error",   32'(error),   0);
      check("b_c3_psel",    32'(psel),    32'h8);
      check("b_c3_penable", 32'(penable), 0);
      check("b_c3_paddr",   32'(paddr),   32'h30);
      check("b_c3_busy",    32'(busy),    1);
      tick();
      check("b_c4_stable",  32'(stable),  0);
      check("b_c4_penable", 32'(penable), 1);
      check("b_c4_pwdata",  32'(pwdata),  32'h22);
      tick();
      pready = 4'b0000;
      check("b_c5_stable", 32'(stable), 1);
      check("b_c5_psel",   32'(psel),   0);
      tick();

      // Invalid sel
      req(1'b1, 3'd5, 8'h77, 8'h01);
      tick();
      start = 1'b0;
      check("s_c1_psel",   32'(psel),   0);
      check("s_c1_busy",   32'(busy),   0);
      check("s_c1_stable", 32'(stable), 1);
      check("s_c1_error",  32'(error),  1);
      check("s_c1_rdata",  32'(rdata),  32'h5A);
      tick();
      check("s_c2_stable", 32'(stable), 0);
      check("s_c2_psel",   32'(psel),   0);

      // Reset during ACCESS
      req(1'b0, 3'd0, 8'h81, 8'h00);
      tick();
      start = 1'b0;
      tick();
      check("x_pre_penable", 32'(penable), 1);
      reset = 1'b0;
      #1;
      check("x_psel",    32'(psel),    0);
      check("x_penable", 32'(penable), 0);
      check("x_paddr",   32'(paddr),   0);
      check("x_busy",    32'(busy),    0);
      check("x_rdata",   32'(rdata),   0);
      check("x_error",   32'(error),   0);
      check("x_stable",  32'(stable),  0);
      pready = 4'b0001;
      tick();
      check("x_hold_stable", 32'(stable), 0);
      reset = 1'b1;
      pready = 4'b0000;
      tick();
      check("x_rel_stable", 32'(stable), 0);

      // Fresh transfer after reset
      req(1'b1, 3'd1, 8'h09, 8'hC3);
      tick();
      start = 1'b0;
      check("n_c1_psel", 32'(psel), 32'h2);
      tick();
      pready = 4'b0010;
      check("n_c2_pwdata", 32'(pwdata), 32'hC3);
      tick();
      pready = 4'b0000;
      check("n_c3_stable", 32'(stable), 1);
      check("n_c3_error",  32'(error),  0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
